// File: rtl/rv_pkg.sv
// Shared constants and types for the RV32I decode-stage register file and
// its pending-write scoreboard.
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int CW    = 2;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef logic [CW-1:0] sb_cnt_t;

    localparam sb_cnt_t SB_MAX = '1;

endpackage

// File: rtl/sb_counter.sv
// One register's pending-writer count: saturating up/down counter with one
// increment and two independent decrement sources applied in the same cycle.
module sb_counter
    import rv_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    inc,
    input  logic    dec_a,
    input  logic    dec_b,
    output sb_cnt_t count,
    output logic    ovf,
    output logic    unf
);

    sb_cnt_t     cnt_q, cnt_d;
    logic [CW:0] up, down, diff;

    // One extra bit of headroom lets the net result be judged before clamping.
    always_comb begin
        up    = {1'b0, cnt_q} + {{CW{1'b0}}, inc};
        down  = {{CW{1'b0}}, dec_a} + {{CW{1'b0}}, dec_b};
        diff  = up - down;
        ovf   = 1'b0;
        unf   = 1'b0;
        cnt_d = diff[CW-1:0];
        if (up < down) begin
            unf   = 1'b1;
            cnt_d = '0;
        end else if (diff > {1'b0, SB_MAX}) begin
            ovf   = 1'b1;
            cnt_d = SB_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-through bypass reads, plus the
// per-register pending-write scoreboard that drives the hazard unit.
module regfile_scoreboard
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic            RegWriteW,
    input  logic [AW-1:0]   RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            IssueD,
    input  logic [AW-1:0]   RDD,
    input  logic            KillE,
    input  logic [AW-1:0]   RDE,
    output logic            Busy1,
    output logic            Busy2,
    output logic            SbOverflow,
    output logic            SbUnderflow
);

    logic [XLEN-1:0] regs_q [NREGS];
    sb_cnt_t         cnt [NREGS];
    logic [NREGS-1:0] ovfVec, unfVec;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic [CW:0]     hit1, hit2;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (RegWriteW && RDW != REG_ZERO) begin
            regs_q[RDW] <= ResultW;
        end
    end

    assign cnt[0]    = '0;
    assign ovfVec[0] = 1'b0;
    assign unfVec[0] = 1'b0;

    for (genvar g = 1; g < NREGS; g++) begin : gen_sb
        sb_counter u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (IssueD    && RDD == AW'(g)),
            .dec_a (RegWriteW && RDW == AW'(g)),
            .dec_b (KillE     && RDE == AW'(g)),
            .count (cnt[g]),
            .ovf   (ovfVec[g]),
            .unf   (unfVec[g])
        );
    end

    assign ovf_d = ovf_q | (|ovfVec);
    assign unf_d = unf_q | (|unfVec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign SbOverflow  = ovf_q;
    assign SbUnderflow = unf_q;

    always_comb begin
        RD1 = regs_q[A1];
        if (A1 == REG_ZERO) begin
            RD1 = '0;
        end else if (RegWriteW && RDW == A1) begin
            RD1 = ResultW;
        end
        RD2 = regs_q[A2];
        if (A2 == REG_ZERO) begin
            RD2 = '0;
        end else if (RegWriteW && RDW == A2) begin
            RD2 = ResultW;
        end
    end

    // A writer retiring or being squashed this cycle no longer holds its source busy.
    always_comb begin
        hit1  = {{CW{1'b0}}, RegWriteW && RDW == A1} + {{CW{1'b0}}, KillE && RDE == A1};
        hit2  = {{CW{1'b0}}, RegWriteW && RDW == A2} + {{CW{1'b0}}, KillE && RDE == A2};
        Busy1 = (A1 != REG_ZERO) && ({1'b0, cnt[A1]} > hit1);
        Busy2 = (A2 != REG_ZERO) && ({1'b0, cnt[A2]} > hit2);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard, checked against a
// plain-arithmetic model of register contents and pending-writer counts.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  A1, A2, RDW, RDD, RDE;
    logic [31:0] RD1, RD2, ResultW;
    logic        RegWriteW, IssueD, KillE;
    logic        Busy1, Busy2, SbOverflow, SbUnderflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] mRegs [32];
    int          mCnt  [32];
    bit          mOvf, mUnf;

    regfile_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .A1          (A1),
        .A2          (A2),
        .RD1         (RD1),
        .RD2         (RD2),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
        .IssueD      (IssueD),
        .RDD         (RDD),
        .KillE       (KillE),
        .RDE         (RDE),
        .Busy1       (Busy1),
        .Busy2       (Busy2),
        .SbOverflow  (SbOverflow),
        .SbUnderflow (SbUnderflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < 32; r++) begin
            mRegs[r] = '0;
            mCnt[r]  = 0;
        end
        mOvf = 1'b0;
        mUnf = 1'b0;
    endtask

    function automatic logic [31:0] expRead(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (RegWriteW && RDW == a) return ResultW;
        return mRegs[a];
    endfunction

    function automatic logic expBusy(input logic [4:0] a);
        int n;
        if (a == 0) return 1'b0;
        n = mCnt[a];
        if (RegWriteW && RDW == a) n--;
        if (KillE && RDE == a) n--;
        return n > 0;
    endfunction

    // Applies the current inputs to the model as the coming clock edge would.
    task automatic modelStep();
        int net;
        if (RegWriteW && RDW != 0) mRegs[RDW] = ResultW;
        for (int r = 1; r < 32; r++) begin
            net = mCnt[r];
            if (IssueD && RDD == r) net++;
            if (RegWriteW && RDW == r) net--;
            if (KillE && RDE == r) net--;
            if (net > 3) begin
                net  = 3;
                mOvf = 1'b1;
            end
            if (net < 0) begin
                net  = 0;
                mUnf = 1'b1;
            end
            mCnt[r] = net;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".RD1"}, RD1, expRead(A1));
        checkOutput({tag, ".RD2"}, RD2, expRead(A2));
        checkOutput({tag, ".Busy1"}, {31'b0, Busy1}, {31'b0, expBusy(A1)});
        checkOutput({tag, ".Busy2"}, {31'b0, Busy2}, {31'b0, expBusy(A2)});
        checkOutput({tag, ".Ovf"}, {31'b0, SbOverflow}, {31'b0, mOvf});
        checkOutput({tag, ".Unf"}, {31'b0, SbUnderflow}, {31'b0, mUnf});
    endtask

    // Called just after a falling edge; checks outputs before the next rising edge.
    task automatic applyStimulus(input string tag,
                                 input logic we, input logic [4:0] rdw, input logic [31:0] res,
                                 input logic iss, input logic [4:0] rdd,
                                 input logic kill, input logic [4:0] rde,
                                 input logic [4:0] a1, input logic [4:0] a2);
        RegWriteW = we;   RDW = rdw;  ResultW = res;
        IssueD    = iss;  RDD = rdd;
        KillE     = kill; RDE = rde;
        A1 = a1; A2 = a2;
        #2;
        checkAll(tag);
        modelStep();
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        applyStimulus(tag, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, a1, a2);
    endtask

    initial begin
        rst = 1'b1;
        RegWriteW = 1'b0; RDW = '0; ResultW = '0;
        IssueD = 1'b0; RDD = '0; KillE = 1'b0; RDE = '0;
        A1 = '0; A2 = '0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        idle("reset", 5'd5, 5'd31);

        applyStimulus("wr7", 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1, 5'd2);
        idle("rd7", 5'd7, 5'd0);
        applyStimulus("wrx0", 1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd7);
        checkOutput("x0zero", RD1, 32'h0);
        applyStimulus("bypass", 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 5'd3);

        applyStimulus("iss9a", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9, 5'd0);
        applyStimulus("iss9b", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9, 5'd0);
        idle("busy9", 5'd9, 5'd9);
        applyStimulus("ret9a", 1'b1, 5'd9, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        applyStimulus("ret9b", 1'b1, 5'd9, 32'h22222222, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        idle("free9", 5'd9, 5'd0);

        applyStimulus("iss4a", 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0, 5'd4, 5'd0);
        applyStimulus("iss4b", 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0, 5'd4, 5'd0);
        applyStimulus("tri4", 1'b1, 5'd4, 32'h44444444, 1'b1, 5'd4, 1'b1, 5'd4, 5'd4, 5'd4);
        idle("left4", 5'd4, 5'd0);
        applyStimulus("kill4", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd4, 5'd4, 5'd0);
        applyStimulus("x0ev", 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd4);

        for (int k = 0; k < 4; k++) begin
            applyStimulus("iss12", 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, 5'd0, 5'd12, 5'd0);
        end
        idle("ovf", 5'd12, 5'd0);
        applyStimulus("ret20", 1'b1, 5'd20, 32'h20202020, 1'b0, 5'd0, 1'b0, 5'd0, 5'd20, 5'd12);
        idle("unf", 5'd20, 5'd7);
        idle("sticky", 5'd12, 5'd7);

        // Asynchronous reset asserted mid-cycle clears the flags without an edge.
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("arst.Ovf", {31'b0, SbOverflow}, {31'b0, mOvf});
        checkOutput("arst.Unf", {31'b0, SbUnderflow}, {31'b0, mUnf});
        checkOutput("arst.RD1", RD1, expRead(A1));
        checkOutput("arst.Busy1", {31'b0, Busy1}, {31'b0, expBusy(A1)});
        @(negedge clk);
        rst = 1'b0;
        idle("postrst", 5'd7, 5'd12);

        for (int n = 0; n < 400; n++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)),
                          ($urandom_range(0, 4) == 0), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 8)), 5'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
